mux_pipe_n: RTL and testbench

//  - Parametrised successor to the 8:1 combinational select mux: N-way, WIDTH-bit selector with a registered output and valid/ready handshake.
//  - Sits between pipeline stages (e.g. EX result select -> MEM latch).
//  - Absorbs downstream stalls without a combinational ready path by using a 2-entry skid buffer.
//  - Out-of-range selects fall to the last input, as in the 8:1 mux.

---
 rtl/lc3b_types.sv | 18 +
 rtl/mux_pipe_skid_reg.sv | 33 +++
 rtl/mux_pipe_n.sv | 146 ++++++++++++++
 tb/tb_mux_pipe_n.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared types and limits for the pipelined N-way select mux.
package lc3b_types;

  // Occupancy of the output register plus skid register.
  typedef enum logic [1:0] {
    MP_EMPTY = 2'd0,
    MP_FULL1 = 2'd1,
    MP_FULL2 = 2'd2
  } mux_pipe_state_t;

  localparam int unsigned MUX_PIPE_MAX_N = 32;

  // Select width for an n-way mux, never narrower than one bit.
  function automatic int unsigned mp_sel_w(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_pipe_skid_reg.sv
// One valid+payload register with load (priority) and clear.
module mux_pipe_skid_reg #(
  parameter int unsigned W = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // Load captures a new beat; clear only drops the valid bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/mux_pipe_n.sv
// N-way WIDTH-bit select mux with registered output and a 2-entry skid
// buffer, valid/ready on both sides, no combinational ready path.
// Optional build macro MUX_PIPE_SEL_CHECK_EN: adds sel_err and zeroes data
// for out-of-range selects instead of clamping to input N-1.
module mux_pipe_n
  import lc3b_types::*;
#(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned N     = 8,
  localparam int unsigned SEL_W = mp_sel_w(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready
`ifdef MUX_PIPE_SEL_CHECK_EN
  , output logic             sel_err
`endif
);

  localparam int unsigned IDX_W = $clog2(N * WIDTH);
`ifdef MUX_PIPE_SEL_CHECK_EN
  localparam int unsigned PW    = WIDTH + 1;
  localparam bit          POW2  = (N == (1 << SEL_W));
`else
  localparam int unsigned PW    = WIDTH;
`endif

  if (N < 2 || N > MUX_PIPE_MAX_N) begin : g_bad_n
    $error("mux_pipe_n: N=%0d outside supported range 2..%0d", N, MUX_PIPE_MAX_N);
  end

  mux_pipe_state_t   state_q, state_d;
  logic              in_ready_q;
  logic              accept_c;
  logic              in_range_c;
  logic [IDX_W-1:0]  base_c;
  logic [WIDTH-1:0]  sel_data_c;
  logic [PW-1:0]     sel_pay_c;
  logic              out_load_c, out_clear_c, out_from_skid_c;
  logic              skid_load_c, skid_clear_c;
  logic              out_vld, skid_vld;
  logic [PW-1:0]     out_pay, skid_pay, out_pay_in;

  // Range-checked indexed part-select of the requested input.
  always_comb begin
    in_range_c = (32'(in_sel) < N);
    base_c     = in_range_c ? IDX_W'(32'(in_sel) * WIDTH) : IDX_W'((N - 1) * WIDTH);
    sel_data_c = in_data[base_c +: WIDTH];
`ifdef MUX_PIPE_SEL_CHECK_EN
    sel_pay_c  = {1'b0, sel_data_c};
    if (!in_range_c && !POW2) begin
      sel_pay_c = {1'b1, WIDTH'(0)};
    end
`else
    sel_pay_c  = sel_data_c;
`endif
  end

  // Next occupancy and register load/clear strobes.
  always_comb begin
    state_d         = state_q;
    out_load_c      = 1'b0;
    out_clear_c     = 1'b0;
    out_from_skid_c = 1'b0;
    skid_load_c     = 1'b0;
    skid_clear_c    = 1'b0;
    accept_c        = in_valid && in_ready_q;
    case (state_q)
      MP_EMPTY: begin
        if (accept_c) begin
          out_load_c = 1'b1;
          state_d    = MP_FULL1;
        end
      end
      MP_FULL1: begin
        if (out_ready) begin
          if (accept_c) begin
            out_load_c = 1'b1;
          end else begin
            out_clear_c = 1'b1;
            state_d     = MP_EMPTY;
          end
        end else if (accept_c) begin
          skid_load_c = 1'b1;
          state_d     = MP_FULL2;
        end
      end
      MP_FULL2: begin
        if (out_ready && skid_vld) begin
          out_load_c      = 1'b1;
          out_from_skid_c = 1'b1;
          skid_clear_c    = 1'b1;
          state_d         = MP_FULL1;
        end
      end
      default: state_d = MP_EMPTY;
    endcase
  end

  // Occupancy state and registered in_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= MP_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != MP_FULL2);
    end
  end

  assign out_pay_in = out_from_skid_c ? skid_pay : sel_pay_c;

  mux_pipe_skid_reg #(.W(PW)) u_out (
    .clk     (clk),
    .reset   (reset),
    .load_i  (out_load_c),
    .clear_i (out_clear_c),
    .data_i  (out_pay_in),
    .valid_o (out_vld),
    .data_o  (out_pay)
  );

  mux_pipe_skid_reg #(.W(PW)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .load_i  (skid_load_c),
    .clear_i (skid_clear_c),
    .data_i  (sel_pay_c),
    .valid_o (skid_vld),
    .data_o  (skid_pay)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_vld;
  assign out_data  = out_pay[WIDTH-1:0];
`ifdef MUX_PIPE_SEL_CHECK_EN
  assign sel_err   = out_pay[WIDTH];
`endif

endmodule

// File: tb/tb_mux_pipe_n.sv
// Directed bench for mux_pipe_n: an N=8 and an N=6 instance share the same
// handshake stimulus; a scoreboard per instance checks data order.
module tb_mux_pipe_n;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] in_data8;
  logic [95:0]  in_data6;
  logic [2:0]   in_sel;
  logic         in_valid;
  logic         out_ready;
  logic         in_ready8, in_ready6;
  logic         out_valid8, out_valid6;
  logic [15:0]  out_data8, out_data6;
`ifdef MUX_PIPE_SEL_CHECK_EN
  logic         sel_err8, sel_err6;
`endif

  int checks = 0;
  int errors = 0;
  logic [16:0] q8[$];
  logic [16:0] q6[$];

  always #5 clk = ~clk;

  mux_pipe_n #(.WIDTH(16), .N(8)) dut8 (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data8),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready8),
    .out_data  (out_data8),
    .out_valid (out_valid8),
    .out_ready (out_ready)
`ifdef MUX_PIPE_SEL_CHECK_EN
    , .sel_err (sel_err8)
`endif
  );

  mux_pipe_n #(.WIDTH(16), .N(6)) dut6 (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data6),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready6),
    .out_data  (out_data6),
    .out_valid (out_valid6),
    .out_ready (out_ready)
`ifdef MUX_PIPE_SEL_CHECK_EN
    , .sel_err (sel_err6)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] exp8(input logic [2:0] sel);
    return {1'b0, 16'h1000 + 16'(sel)};
  endfunction

  function automatic logic [16:0] exp6(input logic [2:0] sel);
    if (sel < 3'd5) return {1'b0, 16'h1000 + 16'(sel)};
    if (sel == 3'd5) return {1'b0, 16'hBEEF};
`ifdef MUX_PIPE_SEL_CHECK_EN
    return {1'b1, 16'h0000};
`else
    return {1'b0, 16'hBEEF};
`endif
  endfunction

  // One clock: handshakes are sampled at the falling edge, then the
  // rising edge is taken and the bench resumes 1 time unit after it.
  task automatic step(input logic v, input logic [2:0] s, input logic r);
    logic [16:0] e;
    in_valid  = v;
    in_sel    = s;
    out_ready = r;
    @(negedge clk);
    if (out_valid8 && out_ready) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $error("FAIL sb8_unexpected observed=%h expected=none", out_data8);
      end else begin
        e = q8.pop_front();
        check("sb8_data", 32'(out_data8), 32'(e[15:0]));
      end
    end
    if (out_valid6 && out_ready) begin
      if (q6.size() == 0) begin
        checks++; errors++;
        $error("FAIL sb6_unexpected observed=%h expected=none", out_data6);
      end else begin
        e = q6.pop_front();
        check("sb6_data", 32'(out_data6), 32'(e[15:0]));
`ifdef MUX_PIPE_SEL_CHECK_EN
        check("sb6_sel_err", 32'(sel_err6), 32'(e[16]));
        check("sb8_sel_err", 32'(sel_err8), 32'(0));
`endif
      end
    end
    if (in_valid && in_ready8) q8.push_back(exp8(in_sel));
    if (in_valid && in_ready6) q6.push_back(exp6(in_sel));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    q8.delete();
    q6.delete();
  endtask

  initial begin
    #200000;
    $error("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 8; k++) in_data8[k*16 +: 16] = 16'h1000 + 16'(k);
    for (int k = 0; k < 5; k++) in_data6[k*16 +: 16] = 16'h1000 + 16'(k);
    in_data6[80 +: 16] = 16'hBEEF;
    in_valid  = 1'b1;
    in_sel    = 3'd3;
    out_ready = 1'b1;

    // Reset held 3 cycles with in_valid high.
    do_reset(3);
    check("rst_out_valid", 32'(out_valid8), 32'(0));
    check("rst_out_data", 32'(out_data8), 32'(0));
    check("rst_in_ready", 32'(in_ready8), 32'(1));
    reset = 1'b0;
    step(1'b0, 3'd0, 1'b1);
    check("rst_no_beat", 32'(out_valid8), 32'(0));

    // Streaming sel 0..7 back to back, 1-cycle latency.
    for (int s = 0; s < 8; s++) begin
      step(1'b1, 3'(s), 1'b1);
      check("stream_valid", 32'(out_valid8), 32'(1));
      check("stream_data", 32'(out_data8), 32'h1000 + 32'(s));
    end
    step(1'b0, 3'd0, 1'b1);
    check("stream_drained", 32'(out_valid8), 32'(0));

    // Backpressure: sel 2,5,7 with out_ready low for 4 cycles.
    step(1'b1, 3'd2, 1'b0);
    check("bp_in_ready_1", 32'(in_ready8), 32'(1));
    step(1'b1, 3'd5, 1'b0);
    check("bp_in_ready_full", 32'(in_ready8), 32'(0));
    check("bp_hold_1002", 32'(out_data8), 32'h1002);
    step(1'b1, 3'd7, 1'b0);
    step(1'b1, 3'd7, 1'b0);
    check("bp_hold_1002_late", 32'(out_data8), 32'h1002);
    check("bp_hold_valid", 32'(out_valid8), 32'(1));
    check("bp_still_blocked", 32'(in_ready8), 32'(0));
    step(1'b1, 3'd7, 1'b1);
    check("bp_skid_to_out", 32'(out_data8), 32'h1005);
    check("bp_in_ready_back", 32'(in_ready8), 32'(1));
    step(1'b1, 3'd7, 1'b1);
    check("bp_third", 32'(out_data8), 32'h1007);
    step(1'b0, 3'd0, 1'b1);
    check("bp_drained", 32'(out_valid8), 32'(0));

    // Simultaneous accept and pop: no bubbles.
    for (int s = 0; s < 6; s++) begin
      step(1'b1, 3'(s + 1), 1'b1);
      check("sim_valid", 32'(out_valid8), 32'(1));
      check("sim_in_ready", 32'(in_ready8), 32'(1));
      check("sim_data", 32'(out_data8), 32'h1001 + 32'(s));
    end
    step(1'b0, 3'd0, 1'b1);

    // Out-of-range select on the 6-input instance, then an in-range beat.
    step(1'b1, 3'd7, 1'b1);
`ifdef MUX_PIPE_SEL_CHECK_EN
    check("oor_data", 32'(out_data6), 32'h0000);
    check("oor_sel_err", 32'(sel_err6), 32'(1));
`else
    check("oor_data", 32'(out_data6), 32'hBEEF);
`endif
    step(1'b1, 3'd1, 1'b1);
    check("oor_next_data", 32'(out_data6), 32'h1001);
`ifdef MUX_PIPE_SEL_CHECK_EN
    check("oor_next_sel_err", 32'(sel_err6), 32'(0));
`endif
    step(1'b0, 3'd0, 1'b1);

    // Reset while both entries are occupied.
    step(1'b1, 3'd1, 1'b0);
    step(1'b1, 3'd2, 1'b0);
    check("f2_in_ready", 32'(in_ready8), 32'(0));
    in_valid = 1'b0;
    do_reset(1);
    reset = 1'b0;
    check("f2_rst_valid", 32'(out_valid8), 32'(0));
    check("f2_rst_in_ready", 32'(in_ready8), 32'(1));
    step(1'b1, 3'd4, 1'b1);
    check("f2_after_data", 32'(out_data8), 32'h1004);
    step(1'b0, 3'd0, 1'b1);
    check("f2_alone", 32'(out_valid8), 32'(0));
    check("sb8_empty_end", 32'(q8.size()), 32'(0));
    check("sb6_empty_end", 32'(q6.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
